// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the MoonCore pipeline sequencer: PC mux selects,
// forwarding selects, sequencer state codes and the forwarding priority helper.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 3;
  localparam int CNT_W = 3;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_JMP = 2'b01;
  localparam logic [1:0] PC_VEC = 2'b10;
  localparam logic [1:0] PC_EPC = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2,
    ST_ISR    = 2'd3
  } hz_state_e;

  // The youngest producer (EX) must win over the older one in MEM.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_fwd.sv
// Combinational operand-forwarding selects and load-use hazard detection
// for the instruction in ID against the EX and MEM producers.
module hazard_fwd
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             id_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwe,
  input  logic             ex_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwe,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             lu
);

  logic ex_alu;
  logic ex_hit_a;
  logic ex_hit_b;

  // A load result is not available from EX/MEM yet, so only ALU results forward from EX.
  assign ex_alu   = ex_regwe & ~ex_load;
  assign ex_hit_a = ex_rd == id_rd;
  assign ex_hit_b = ex_rd == id_rs;

  assign fwd_a = fwd_sel(id_use_a & ex_alu & ex_hit_a, mem_regwe & (mem_rd == id_rd));
  assign fwd_b = fwd_sel(id_use_b & ex_alu & ex_hit_b, mem_regwe & (mem_rd == id_rs));

  assign lu = id_valid & ex_regwe & ex_load & ((id_use_a & ex_hit_a) | (id_use_b & ex_hit_b));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// MoonCore pipeline sequencer: load-use stall, redirect squash, forwarding
// and interrupt entry/return sequencing.
//
// state  | meaning
// RUN    | normal issue, watching for an enabled interrupt
// DRAIN  | IF held, bubbles issued while in-flight instrs retire
// VECTOR | fetch redirected to IRQ_VEC, irq acknowledged
// ISR    | handler running, irq masked until ex_iret
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int                   CPU_WIDTH = 16,
  parameter int                   DRAIN_CYC = 3,
  parameter logic [CPU_WIDTH-1:0] IRQ_VEC   = 16'h0004
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_W-1:0]     id_rd,
  input  logic [REG_W-1:0]     id_rs,
  input  logic                 id_use_a,
  input  logic                 id_use_b,
  input  logic                 id_valid,
  input  logic [REG_W-1:0]     ex_rd,
  input  logic                 ex_regwe,
  input  logic                 ex_load,
  input  logic [REG_W-1:0]     mem_rd,
  input  logic                 mem_regwe,
  input  logic                 ex_take,
  input  logic [CPU_WIDTH-1:0] ex_target,
  input  logic                 ex_iret,
  input  logic [CPU_WIDTH-1:0] if_pc,
  input  logic                 irq,
  input  logic                 irq_en,
  output logic                 stall_if,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [1:0]           pc_sel,
  output logic [CPU_WIDTH-1:0] epc,
  output logic                 irq_ack,
  output logic                 int_active
);

  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(1);

  hz_state_e            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CPU_WIDTH-1:0] epc_nxt;
  logic                 int_active_nxt;
  logic [1:0]           fwd_a_raw, fwd_b_raw;
  logic                 lu;

  hazard_fwd u_hazard_fwd (
    .id_rd     (id_rd),
    .id_rs     (id_rs),
    .id_use_a  (id_use_a),
    .id_use_b  (id_use_b),
    .id_valid  (id_valid),
    .ex_rd     (ex_rd),
    .ex_regwe  (ex_regwe),
    .ex_load   (ex_load),
    .mem_rd    (mem_rd),
    .mem_regwe (mem_regwe),
    .fwd_a     (fwd_a_raw),
    .fwd_b     (fwd_b_raw),
    .lu        (lu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      cnt        <= '0;
      epc        <= '0;
      int_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      epc        <= epc_nxt;
      int_active <= int_active_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    epc_nxt        = epc;
    int_active_nxt = int_active;
    stall_if       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    pc_sel         = PC_SEQ;
    irq_ack        = 1'b0;
    fwd_a          = fwd_a_raw;
    fwd_b          = fwd_b_raw;

    // A taken redirect squashes the consumer anyway, so the load-use stall is dropped.
    if (lu && !ex_take) begin
      stall_if = 1'b1;
      flush_ex = 1'b1;
    end
    if (ex_take) begin
      pc_sel   = PC_JMP;
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end

    unique case (state)
      ST_RUN: begin
        if (irq && irq_en && !lu && !ex_take) begin
          state_nxt = ST_DRAIN;
          epc_nxt   = if_pc;
          cnt_nxt   = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        stall_if = 1'b1;
        flush_id = 1'b1;
        cnt_nxt  = cnt - DRAIN_LAST;
        // A redirect retiring during drain is where the interrupted program resumes.
        if (ex_take) epc_nxt = ex_target;
        if (cnt == DRAIN_LAST) state_nxt = ST_VECTOR;
      end
      ST_VECTOR: begin
        pc_sel         = PC_VEC;
        flush_id       = 1'b1;
        irq_ack        = 1'b1;
        int_active_nxt = 1'b1;
        state_nxt      = ST_ISR;
      end
      ST_ISR: begin
        if (ex_iret) begin
          pc_sel         = PC_EPC;
          flush_id       = 1'b1;
          flush_ex       = 1'b1;
          int_active_nxt = 1'b0;
          state_nxt      = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (rst) begin
      stall_if = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      pc_sel   = PC_SEQ;
      irq_ack  = 1'b0;
      fwd_a    = FWD_RF;
      fwd_b    = FWD_RF;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// stimulus compared against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rd, id_rs, ex_rd, mem_rd;
  logic        id_use_a, id_use_b, id_valid, ex_regwe, ex_load, mem_regwe;
  logic        ex_take, ex_iret, irq, irq_en;
  logic [15:0] ex_target, if_pc;
  logic        stall_if, flush_id, flush_ex, irq_ack, int_active;
  logic [1:0]  fwd_a, fwd_b, pc_sel;
  logic [15:0] epc;

  int checks = 0;
  int errors = 0;

  // model: where the interrupt sequence stands, in plain terms
  int          m_drain_left;
  bit          m_vector_now;
  bit          m_in_handler;
  logic [15:0] m_epc;
  bit          m_int_active;

  logic [1:0]  e_fwd_a, e_fwd_b, e_pc_sel;
  logic        e_stall, e_flush_id, e_flush_ex, e_ack, e_lu;

  pipe_hazard_ctrl #(.CPU_WIDTH(16), .DRAIN_CYC(DRAIN), .IRQ_VEC(16'h0004)) dut (
    .clk(clk), .rst(rst),
    .id_rd(id_rd), .id_rs(id_rs), .id_use_a(id_use_a), .id_use_b(id_use_b), .id_valid(id_valid),
    .ex_rd(ex_rd), .ex_regwe(ex_regwe), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_regwe(mem_regwe),
    .ex_take(ex_take), .ex_target(ex_target), .ex_iret(ex_iret),
    .if_pc(if_pc), .irq(irq), .irq_en(irq_en),
    .stall_if(stall_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_sel(pc_sel),
    .epc(epc), .irq_ack(irq_ack), .int_active(int_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [1:0] ref_fwd(input logic use_op, input logic [2:0] r);
    if (use_op && ex_regwe && !ex_load && ex_rd == r) return 2'd1;
    if (mem_regwe && mem_rd == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_outputs();
    bit draining, iret_now;
    draining   = m_drain_left > 0;
    iret_now   = m_in_handler && ex_iret;
    e_lu       = id_valid && ex_regwe && ex_load &&
                 ((id_use_a && ex_rd == id_rd) || (id_use_b && ex_rd == id_rs));
    e_fwd_a    = ref_fwd(id_use_a, id_rd);
    e_fwd_b    = ref_fwd(id_use_b, id_rs);
    e_stall    = (e_lu && !ex_take) || draining;
    e_flush_id = ex_take || draining || m_vector_now || iret_now;
    e_flush_ex = e_lu || ex_take || iret_now;
    e_ack      = m_vector_now;
    if (m_vector_now)  e_pc_sel = 2'd2;
    else if (iret_now) e_pc_sel = 2'd3;
    else if (ex_take)  e_pc_sel = 2'd1;
    else               e_pc_sel = 2'd0;
    if (rst) begin
      {e_stall, e_flush_id, e_flush_ex, e_ack} = '0;
      e_fwd_a = 2'd0; e_fwd_b = 2'd0; e_pc_sel = 2'd0;
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      m_drain_left = 0; m_vector_now = 0; m_in_handler = 0; m_epc = '0; m_int_active = 0;
    end else if (m_drain_left > 0) begin
      if (ex_take) m_epc = ex_target;
      m_drain_left--;
      if (m_drain_left == 0) m_vector_now = 1;
    end else if (m_vector_now) begin
      m_vector_now = 0; m_in_handler = 1; m_int_active = 1;
    end else if (m_in_handler) begin
      if (ex_iret) begin m_in_handler = 0; m_int_active = 0; end
    end else if (irq && irq_en && !e_lu && !ex_take) begin
      m_drain_left = DRAIN; m_epc = if_pc;
    end
  endtask

  task automatic clear_inputs();
    rst = 0; id_rd = 0; id_rs = 0; id_use_a = 0; id_use_b = 0; id_valid = 0;
    ex_rd = 0; ex_regwe = 0; ex_load = 0; mem_rd = 0; mem_regwe = 0;
    ex_take = 0; ex_target = 0; ex_iret = 0; if_pc = 0; irq = 0; irq_en = 0;
  endtask

  task automatic settle();
    #2;
    model_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    settle();
    model_advance();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; ex_take = 1; ex_regwe = 1; mem_regwe = 1; id_use_a = 1; irq = 1; irq_en = 1;
    ex_load = 1; id_valid = 1;
    settle();
    checks++;
    if ({stall_if, flush_id, flush_ex, irq_ack, fwd_a, fwd_b, pc_sel} !== '0) begin
      errors++;
      $display("FAIL reset_comb: got stall=%b fid=%b fex=%b ack=%b fa=%0d fb=%0d pc=%0d, want all 0",
               stall_if, flush_id, flush_ex, irq_ack, fwd_a, fwd_b, pc_sel);
    end
    model_advance();
    @(negedge clk);
    clear_inputs();
    settle();
    checks++;
    if (epc !== 16'h0 || int_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: epc=%h int_active=%b, want 0000 0", epc, int_active);
    end
    model_advance();
  endtask

  task automatic test_forwarding();
    do_reset();
    clear_inputs();
    ex_rd = 1; ex_regwe = 1; id_rd = 1; id_use_a = 1; id_valid = 1;
    settle();
    checks++;
    if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_ex_a: got %b want 01", fwd_a); end
    model_advance();
    @(negedge clk);
    mem_rd = 1; mem_regwe = 1;
    settle();
    checks++;
    if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_ex_beats_mem: got %b want 01", fwd_a); end
    model_advance();
    @(negedge clk);
    ex_regwe = 0; id_rs = 0; mem_rd = 0; id_rd = 0; id_use_b = 1;
    settle();
    checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      errors++; $display("FAIL fwd_mem_r0: got a=%b b=%b want 10 10", fwd_a, fwd_b);
    end
    model_advance();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      id_rd = 3'($urandom_range(0, 3)); id_rs = 3'($urandom_range(0, 3));
      ex_rd = 3'($urandom_range(0, 3)); mem_rd = 3'($urandom_range(0, 3));
      id_use_a = 1'($urandom); id_use_b = 1'($urandom);
      ex_regwe = 1'($urandom); ex_load = 1'($urandom); mem_regwe = 1'($urandom);
      id_valid = 0;
      settle();
      checks++;
      if (fwd_a !== e_fwd_a || fwd_b !== e_fwd_b) begin
        errors++;
        $display("FAIL fwd_random: got a=%b b=%b want a=%b b=%b", fwd_a, fwd_b, e_fwd_a, e_fwd_b);
      end
      model_advance();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    clear_inputs();
    ex_rd = 2; ex_regwe = 1; ex_load = 1; id_rs = 2; id_use_b = 1; id_valid = 1; id_rd = 5;
    settle();
    checks++;
    if (stall_if !== 1'b1 || flush_ex !== 1'b1 || flush_id !== 1'b0) begin
      errors++; $display("FAIL lu_stall: got stall=%b fex=%b fid=%b want 1 1 0", stall_if, flush_ex, flush_id);
    end
    model_advance();
    @(negedge clk);
    ex_regwe = 0; ex_load = 0; ex_rd = 0; mem_rd = 2; mem_regwe = 1;
    settle();
    checks++;
    if (fwd_b !== 2'b10 || stall_if !== 1'b0 || flush_ex !== 1'b0) begin
      errors++; $display("FAIL lu_followup: got fb=%b stall=%b fex=%b want 10 0 0", fwd_b, stall_if, flush_ex);
    end
    model_advance();
    @(negedge clk);
    ex_rd = 2; ex_regwe = 1; ex_load = 1; mem_regwe = 0; ex_take = 1; ex_target = 16'h0100;
    settle();
    checks++;
    if (pc_sel !== 2'b01 || flush_id !== 1'b1 || flush_ex !== 1'b1 || stall_if !== 1'b0) begin
      errors++;
      $display("FAIL lu_vs_take: got pc=%b fid=%b fex=%b stall=%b want 01 1 1 0", pc_sel, flush_id, flush_ex, stall_if);
    end
    model_advance();
  endtask

  task automatic test_irq_entry();
    bit found;
    do_reset();
    clear_inputs();
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if_pc = 16'h0020 + 16'(i);
      irq = (i == 0); irq_en = 1;
      settle();
      if (i >= 1 && i <= DRAIN) begin
        checks++;
        if (stall_if !== 1'b1 || flush_id !== 1'b1) begin
          errors++; $display("FAIL drain_bubbles: cycle %0d stall=%b fid=%b want 1 1", i, stall_if, flush_id);
        end
      end
      if (irq_ack === 1'b1) begin
        found = 1;
        checks++;
        if (i != DRAIN + 1 || pc_sel !== 2'b10 || epc !== 16'h0020) begin
          errors++;
          $display("FAIL vector: cycle %0d pc=%b epc=%h want cycle %0d pc=10 epc=0020", i, pc_sel, epc, DRAIN + 1);
        end
      end
      model_advance();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL irq_ack_timeout: got no irq_ack, want one"); end
    @(negedge clk);
    irq = 0;
    settle();
    checks++;
    if (int_active !== 1'b1) begin errors++; $display("FAIL int_active_set: got %b want 1", int_active); end
    model_advance();
  endtask

  task automatic test_drain_redirect_iret();
    bit found;
    do_reset();
    clear_inputs();
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if_pc = 16'h0030; irq_en = 1; irq = (i == 0);
      ex_take = (i == 2); ex_target = (i == 2) ? 16'h0040 : 16'h0;
      settle();
      if (i == 2) begin
        checks++;
        if (pc_sel !== 2'b01 || stall_if !== 1'b1) begin
          errors++; $display("FAIL drain_take: got pc=%b stall=%b want 01 1", pc_sel, stall_if);
        end
      end
      found = irq_ack === 1'b1;
      model_advance();
    end
    ex_take = 0;
    @(negedge clk);
    irq = 1;
    settle();
    checks++;
    if (epc !== 16'h0040 || int_active !== 1'b1 || stall_if !== 1'b0) begin
      errors++; $display("FAIL isr_state: got epc=%h ia=%b stall=%b want 0040 1 0", epc, int_active, stall_if);
    end
    model_advance();
    @(negedge clk);
    irq = 0; ex_iret = 1; ex_take = 1; ex_target = 16'h0099;
    settle();
    checks++;
    if (pc_sel !== 2'b11 || flush_id !== 1'b1 || flush_ex !== 1'b1) begin
      errors++; $display("FAIL iret: got pc=%b fid=%b fex=%b want 11 1 1", pc_sel, flush_id, flush_ex);
    end
    model_advance();
    @(negedge clk);
    ex_iret = 0; ex_take = 0; irq = 1;
    settle();
    checks++;
    if (int_active !== 1'b0) begin errors++; $display("FAIL iret_clear: got int_active=%b want 0", int_active); end
    model_advance();
    @(negedge clk);
    irq = 0;
    settle();
    checks++;
    if (stall_if !== 1'b1) begin errors++; $display("FAIL back_in_run: got stall=%b want 1 (new drain)", stall_if); end
    model_advance();
  endtask

  task automatic test_reset_mid_isr();
    do_reset();
    clear_inputs();
    for (int i = 0; i < DRAIN + 3; i++) begin
      @(negedge clk);
      irq = 1; irq_en = 1; if_pc = 16'h0077;
      settle();
      model_advance();
    end
    @(negedge clk);
    rst = 1;
    settle();
    checks++;
    if (int_active !== 1'b1 || stall_if !== 1'b0) begin
      errors++; $display("FAIL pre_rst_isr: got ia=%b stall=%b want 1 0", int_active, stall_if);
    end
    model_advance();
    @(negedge clk);
    rst = 0; irq = 1; irq_en = 0;
    settle();
    checks++;
    if (epc !== 16'h0 || int_active !== 1'b0) begin
      errors++; $display("FAIL rst_isr: got epc=%h ia=%b want 0000 0", epc, int_active);
    end
    model_advance();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      settle();
      checks++;
      if (stall_if !== 1'b0 || irq_ack !== 1'b0) begin
        errors++; $display("FAIL irq_masked_en: cycle %0d stall=%b ack=%b want 0 0", i, stall_if, irq_ack);
      end
      model_advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 99) == 0;
      id_rd = 3'($urandom_range(0, 3)); id_rs = 3'($urandom_range(0, 3));
      ex_rd = 3'($urandom_range(0, 3)); mem_rd = 3'($urandom_range(0, 3));
      id_use_a = 1'($urandom); id_use_b = 1'($urandom); id_valid = 1'($urandom);
      ex_regwe = 1'($urandom); ex_load = $urandom_range(0, 2) == 0; mem_regwe = 1'($urandom);
      ex_take = $urandom_range(0, 5) == 0; ex_target = 16'($urandom);
      ex_iret = $urandom_range(0, 5) == 0; if_pc = 16'($urandom);
      irq = $urandom_range(0, 4) == 0; irq_en = $urandom_range(0, 3) != 0;
      settle();
      checks++;
      if ({fwd_a, fwd_b, pc_sel, stall_if, flush_id, flush_ex, irq_ack, epc, int_active} !==
          {e_fwd_a, e_fwd_b, e_pc_sel, e_stall, e_flush_id, e_flush_ex, e_ack, m_epc, m_int_active}) begin
        errors++;
        $display("FAIL random_cycle %0d: got fa=%b fb=%b pc=%b st=%b fid=%b fex=%b ack=%b epc=%h ia=%b want fa=%b fb=%b pc=%b st=%b fid=%b fex=%b ack=%b epc=%h ia=%b",
                 i, fwd_a, fwd_b, pc_sel, stall_if, flush_id, flush_ex, irq_ack, epc, int_active,
                 e_fwd_a, e_fwd_b, e_pc_sel, e_stall, e_flush_id, e_flush_ex, e_ack, m_epc, m_int_active);
      end
      model_advance();
    end
  endtask

  initial begin
    clear_inputs();
    m_drain_left = 0; m_vector_now = 0; m_in_handler = 0; m_epc = '0; m_int_active = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_irq_entry();
    test_drain_redirect_iret();
    test_reset_mid_isr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
